// File: rtl/mult_sequencer.sv
// Control sequencer for the shift-add multiplier datapath (X, Y, Z registers plus ULA).
// Captures operands on start, then iterates WIDTH accumulate/shift steps with an optional early exit.
module mult_sequencer #(
    parameter int WIDTH      = 4,
    parameter int CNT_W      = 4,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_y,
    output logic [WIDTH-1:0] val,
    output logic [1:0]       ctrl_x,
    output logic [1:0]       ctrl_y,
    output logic [1:0]       ctrl_z,
    output logic             ula_op,
    output logic [2:0]       step,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    // state  | meaning
    // IDLE   | waiting for start, operands captured on acceptance
    // LOAD_X | load multiplicand into X, clear Y and Z
    // LOAD_Y | load multiplier into Y, reset iteration counter
    // ACC    | add X into Z when the current multiplier bit is set
    // SHIFT  | shift X left and Y right, advance iteration counter
    // FINISH | one-cycle done pulse, result held in Z
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        LOAD_X = 3'b001,
        LOAD_Y = 3'b010,
        ACC    = 3'b011,
        SHIFT  = 3'b100,
        FINISH = 3'b101
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   xr;
    logic [WIDTH-1:0]   yr;
    logic [WIDTH-1:0]   ysh;
    logic               ysh_zero;

    assign ysh_zero = (ysh == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            xr      <= '0;
            yr      <= '0;
            ysh     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        xr  <= op_x;
                        yr  <= op_y;
                        ysh <= op_y;
                    end
                end
                LOAD_Y: count_q <= '0;
                SHIFT: begin
                    ysh <= ysh >> 1;
                    // counter saturates at the last iteration so it never wraps
                    if (count_q != LAST) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        val     = '0;
        ctrl_x  = 2'b00;
        ctrl_y  = 2'b00;
        ctrl_z  = 2'b00;
        ula_op  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_X;
                end
            end
            LOAD_X: begin
                ctrl_x  = 2'b01;
                ctrl_y  = 2'b11;
                ctrl_z  = 2'b11;
                ula_op  = 1'b1;
                val     = xr;
                state_d = LOAD_Y;
            end
            LOAD_Y: begin
                ctrl_y  = 2'b01;
                val     = yr;
                state_d = ACC;
            end
            ACC: begin
                if ((EARLY_EXIT != 0) && ysh_zero) begin
                    state_d = FINISH;
                end else begin
                    ctrl_z  = ysh[0] ? 2'b01 : 2'b00;
                    ula_op  = ysh[0];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ctrl_x  = 2'b10;
                ctrl_y  = 2'b10;
                state_d = (count_q == LAST) ? FINISH : ACC;
            end
            FINISH: begin
                ctrl_x  = 2'b11;
                ctrl_y  = 2'b11;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign step  = state_q;
    assign count = count_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: a reference model pushes the expected per-cycle
// output trace of each run into a scoreboard queue, popped and compared cycle by cycle.
module tb_mult_sequencer;

    typedef struct packed {
        logic [2:0] step;
        logic [3:0] val;
        logic [1:0] cx;
        logic [1:0] cy;
        logic [1:0] cz;
        logic       ula;
        logic [3:0] cnt;
        logic       busy;
        logic       done;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, start1, start2;
    logic [3:0] ox, oy;
    logic       ox2, oy2;

    logic [3:0] val0, val1;
    logic       val2;
    logic [1:0] cx0, cy0, cz0, cx1, cy1, cz1, cx2, cy2, cz2;
    logic       ula0, ula1, ula2;
    logic [2:0] step0, step1, step2;
    logic [3:0] cnt0, cnt1, cnt2;
    logic       busy0, busy1, busy2, done0, done1, done2;

    mult_sequencer #(.WIDTH(4), .CNT_W(4), .EARLY_EXIT(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .op_x(ox), .op_y(oy),
        .val(val0), .ctrl_x(cx0), .ctrl_y(cy0), .ctrl_z(cz0), .ula_op(ula0),
        .step(step0), .count(cnt0), .busy(busy0), .done(done0));

    mult_sequencer #(.WIDTH(4), .CNT_W(4), .EARLY_EXIT(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .op_x(ox), .op_y(oy),
        .val(val1), .ctrl_x(cx1), .ctrl_y(cy1), .ctrl_z(cz1), .ula_op(ula1),
        .step(step1), .count(cnt1), .busy(busy1), .done(done1));

    mult_sequencer #(.WIDTH(1), .CNT_W(4), .EARLY_EXIT(0)) u2 (
        .clk(clk), .rst(rst), .start(start2), .op_x(ox2), .op_y(oy2),
        .val(val2), .ctrl_x(cx2), .ctrl_y(cy2), .ctrl_z(cz2), .ula_op(ula2),
        .step(step2), .count(cnt2), .busy(busy2), .done(done2));

    int   ntests = 0;
    int   nfail  = 0;
    int   mcnt[3];
    rec_t sb[$];

    function automatic rec_t sample(input int inst);
        rec_t r;
        case (inst)
            0:       r = {step0, val0, cx0, cy0, cz0, ula0, cnt0, busy0, done0};
            1:       r = {step1, val1, cx1, cy1, cz1, ula1, cnt1, busy1, done1};
            default: r = {step2, 3'b000, val2, cx2, cy2, cz2, ula2, cnt2, busy2, done2};
        endcase
        return r;
    endfunction

    function automatic rec_t idle_rec(input int inst);
        rec_t r;
        r     = '0;
        r.cnt = 4'(mcnt[inst]);
        return r;
    endfunction

    // Reference model: expected output trace of one run, from LOAD_X through FINISH.
    task automatic gen(input int inst, input int w, input bit ee,
                       input logic [3:0] x, input logic [3:0] y);
        rec_t       r;
        logic [3:0] ysh;
        int         cnt;
        ysh = y;
        cnt = 0;
        r = '0;
        r.step = 3'd1; r.val = x; r.cx = 2'd1; r.cy = 2'd3; r.cz = 2'd3; r.ula = 1'b1;
        r.cnt = 4'(mcnt[inst]); r.busy = 1'b1;
        sb.push_back(r);
        r.step = 3'd2; r.val = y; r.cx = 2'd0; r.cy = 2'd1; r.cz = 2'd0; r.ula = 1'b0;
        sb.push_back(r);
        while (1) begin
            r.step = 3'd3; r.val = 4'd0; r.cx = 2'd0; r.cy = 2'd0; r.cnt = 4'(cnt);
            if (ee && ysh == 4'd0) begin
                r.cz = 2'd0; r.ula = 1'b0;
                sb.push_back(r);
                break;
            end
            r.cz = ysh[0] ? 2'd1 : 2'd0; r.ula = ysh[0];
            sb.push_back(r);
            r.step = 3'd4; r.cx = 2'd2; r.cy = 2'd2; r.cz = 2'd0; r.ula = 1'b0;
            sb.push_back(r);
            ysh = ysh >> 1;
            if (cnt == w - 1) break;
            cnt++;
        end
        r.step = 3'd5; r.val = 4'd0; r.cx = 2'd3; r.cy = 2'd3; r.cz = 2'd0; r.ula = 1'b0;
        r.cnt = 4'(cnt); r.done = 1'b1;
        sb.push_back(r);
        mcnt[inst] = cnt;
    endtask

    task automatic test_reset();
        rec_t obs, exp;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                obs = sample(i);
                exp = idle_rec(i);
                ntests++;
                if (obs !== exp) begin
                    nfail++;
                    $display("FAIL reset u%0d cyc%0d: got %h want %h", i, c, obs, exp);
                end
            end
        end
    endtask

    task automatic test_basic();
        rec_t obs, exp;
        sb.delete();
        ox = 4'd3; oy = 4'd5;
        gen(0, 4, 1'b0, 4'd3, 4'd5);
        start0 = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            obs = sample(0);
            exp = (sb.size() > 0) ? sb.pop_front() : idle_rec(0);
            ntests++;
            if (obs !== exp) begin
                nfail++;
                $display("FAIL basic cyc%0d: got %h want %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_early_exit();
        rec_t obs, exp;
        logic [3:0] ys[2];
        ys[0] = 4'd1; ys[1] = 4'd0;
        for (int k = 0; k < 2; k++) begin
            sb.delete();
            ox = 4'd6 + 4'(k); oy = ys[k];
            gen(1, 4, 1'b1, ox, ys[k]);
            start1 = 1'b1;
            for (int c = 1; c <= 8; c++) begin
                @(posedge clk); #1;
                start1 = 1'b0;
                obs = sample(1);
                exp = (sb.size() > 0) ? sb.pop_front() : idle_rec(1);
                ntests++;
                if (obs !== exp) begin
                    nfail++;
                    $display("FAIL early_exit y=%0d cyc%0d: got %h want %h", ys[k], c, obs, exp);
                end
            end
        end
    endtask

    task automatic test_width1();
        rec_t obs, exp;
        sb.delete();
        ox2 = 1'b1; oy2 = 1'b1;
        gen(2, 1, 1'b0, 4'd1, 4'd1);
        start2 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            obs = sample(2);
            exp = (sb.size() > 0) ? sb.pop_front() : idle_rec(2);
            ntests++;
            if (obs !== exp) begin
                nfail++;
                $display("FAIL width1 cyc%0d: got %h want %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_midrun_reset();
        rec_t obs, exp;
        sb.delete();
        ox = 4'd5; oy = 4'd6;
        gen(0, 4, 1'b0, 4'd5, 4'd6);
        start0 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (c == 1) start0 = 1'b0;
            obs = sample(0);
            exp = sb.pop_front();
            ntests++;
            if (obs !== exp) begin
                nfail++;
                $display("FAIL midrun cyc%0d: got %h want %h", c, obs, exp);
            end
            if (c == 4) begin
                ox = 4'd9; oy = 4'd15; start0 = 1'b1;
            end
            if (c == 5) start0 = 1'b0;
            if (c == 7) rst = 1'b1;
        end
        sb.delete();
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        for (int c = 8; c <= 11; c++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            obs = sample(0);
            exp = idle_rec(0);
            ntests++;
            if (obs !== exp) begin
                nfail++;
                $display("FAIL midrun_reset cyc%0d: got %h want %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t obs, exp;
        int   len;
        sb.delete();
        ox = 4'd7; oy = 4'd3;
        for (int k = 0; k < 3; k++) begin
            gen(1, 4, 1'b1, 4'd7, 4'd3);
            sb.push_back(idle_rec(1));
        end
        len = sb.size() / 3;
        start1 = 1'b1;
        for (int c = 1; c <= 3 * len + 2; c++) begin
            @(posedge clk); #1;
            if (c == 3 * len - 1) start1 = 1'b0;
            obs = sample(1);
            exp = (sb.size() > 0) ? sb.pop_front() : idle_rec(1);
            ntests++;
            if (obs !== exp) begin
                nfail++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", c, obs, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        ox = 4'd0; oy = 4'd0; ox2 = 1'b0; oy2 = 1'b0;
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_basic();
        test_early_exit();
        test_width1();
        test_midrun_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
